// File: rtl/accel_pkg.sv
// accel_pkg: shared state encoding and default widths for the strobe generators
package accel_pkg;

   localparam int PD_CNT_W = 8;
   localparam int PD_GAP_W = 4;

   typedef enum logic [1:0] {
      PD_IDLE  = 2'd0,
      PD_PULSE = 2'd1,
      PD_GAP   = 2'd2
   } pd_state_e;

endpackage

// File: rtl/pulse_gap_timer.sv
// pulse_gap_timer: loadable down-counter that flags the last cycle of a programmed interval
module pulse_gap_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // expire marks the final counting cycle so the caller can leave on the next edge
   assign expire_o = en_i && (cnt_q == W'(1));

   // load wins over counting; the counter parks at zero rather than wrapping
   always_comb begin
      cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   end

   // counter register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pulse_dispenser.sv
// pulse_dispenser: emits N single-cycle pulses spaced gap+1 cycles apart per accepted request
module pulse_dispenser
   import accel_pkg::*;
#(
   parameter int CNT_W = PD_CNT_W,
   parameter int GAP_W = PD_GAP_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CNT_W-1:0] req_count,
   input  logic [GAP_W-1:0] req_gap,
   input  logic             abort,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] emitted
);

   pd_state_e        state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] emitted_q, emitted_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             done_q, done_d;
   logic             accept;
   logic             tmr_load;
   logic             tmr_expire;

   // outputs decode registered state only, so no input reaches them combinationally
   assign pulse_out = (state_q == PD_PULSE);
   assign busy      = (state_q != PD_IDLE);
   assign done      = done_q;
   assign emitted   = emitted_q;
   assign req_ready = (state_q == PD_IDLE) && !abort;
   assign accept    = req_valid && req_ready;

   pulse_gap_timer #(
      .W(GAP_W)
   ) u_gap_timer (
      .clk       (clk),
      .rstn      (rstn),
      .load_i    (tmr_load),
      .load_val_i(gap_q),
      .en_i      (state_q == PD_GAP),
      .expire_o  (tmr_expire)
   );

   // next-state logic: abort beats everything, a zero-count request completes at once
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      gap_d       = gap_q;
      emitted_d   = emitted_q;
      done_d      = 1'b0;
      tmr_load    = 1'b0;
      case (state_q)
         PD_IDLE: begin
            if (accept) begin
               emitted_d = '0;
               if (req_count != '0) begin
                  remaining_d = req_count;
                  gap_d       = req_gap;
                  state_d     = PD_PULSE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         PD_PULSE: begin
            emitted_d   = emitted_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (abort) begin
               state_d = PD_IDLE;
            end else if (remaining_q == CNT_W'(1)) begin
               state_d = PD_IDLE;
               done_d  = 1'b1;
            end else if (gap_q != '0) begin
               state_d  = PD_GAP;
               tmr_load = 1'b1;
            end
         end
         PD_GAP: begin
            state_d = abort ? PD_IDLE : tmr_expire ? PD_PULSE : PD_GAP;
         end
         default: state_d = PD_IDLE;
      endcase
   end

   // state and counter registers; reset drops any burst without a done strobe
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= PD_IDLE;
         remaining_q <= '0;
         emitted_q   <= '0;
         gap_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         emitted_q   <= emitted_d;
         gap_q       <= gap_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_pulse_dispenser.sv
// tb_pulse_dispenser: scoreboard bench with a cycle-timeline reference model of pulse bursts
module tb_pulse_dispenser;

   localparam int CNT_W = 8;
   localparam int GAP_W = 4;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             req_valid = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] req_count = '0;
   logic [GAP_W-1:0] req_gap = '0;
   logic             req_ready, pulse_out, busy, done;
   logic [CNT_W-1:0] emitted;

   typedef struct {
      int cyc;
      bit is_done;
      int em;
   } ev_t;

   ev_t exp_q[$];
   int  cyc = 0;
   int  n_vec = 0;
   int  n_err = 0;
   int  exp_cyc = -1;
   bit  exp_ready = 1'b0;
   bit  exp_busy = 1'b0;
   int  chk_em_cyc = -1;
   int  chk_em_val = 0;
   int  b_from = 1, b_to = 0, b_t = 0, b_cnt = 0, b_gap = 0;

   pulse_dispenser #(
      .CNT_W(CNT_W),
      .GAP_W(GAP_W)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_count(req_count),
      .req_gap  (req_gap),
      .abort    (abort),
      .pulse_out(pulse_out),
      .busy     (busy),
      .done     (done),
      .emitted  (emitted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit model_busy(input int c);
      return c >= b_from && c <= b_to;
   endfunction

   // accepted at cycle t: pulse k lands at t+1+k*(gap+1), done one cycle after the last
   task automatic model_accept(input int t, input int cnt, input int gap);
      if (cnt == 0) begin
         exp_q.push_back('{cyc: t + 1, is_done: 1'b1, em: 0});
      end else begin
         for (int k = 0; k < cnt; k++) exp_q.push_back('{cyc: t + 1 + k * (gap + 1), is_done: 1'b0, em: k});
         b_t    = t;
         b_cnt  = cnt;
         b_gap  = gap;
         b_from = t + 1;
         b_to   = t + 1 + (cnt - 1) * (gap + 1);
         exp_q.push_back('{cyc: b_to + 1, is_done: 1'b1, em: cnt});
      end
   endtask

   // abort at cycle a keeps every event up to and including a, drops the rest
   task automatic model_abort(input int a);
      ev_t keep[$];
      int  n;
      n = (a - b_t - 1) / (b_gap + 1) + 1;
      if (n > b_cnt) n = b_cnt;
      foreach (exp_q[i]) if (exp_q[i].cyc <= a) keep.push_back(exp_q[i]);
      exp_q      = keep;
      b_to       = a;
      chk_em_cyc = a + 1;
      chk_em_val = n;
   endtask

   task automatic step(input bit v, input int cnt, input int gap, input bit ab, output bit acc);
      req_valid = v;
      req_count = CNT_W'(cnt);
      req_gap   = GAP_W'(gap);
      abort     = ab;
      exp_busy  = model_busy(cyc);
      exp_ready = !exp_busy && !ab;
      exp_cyc   = cyc;
      acc       = v && exp_ready;
      if (ab && exp_busy) model_abort(cyc);
      if (acc) model_accept(cyc, cnt, gap);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int ab_pct);
      bit acc;
      step(1'b0, int'($urandom_range(255)), int'($urandom_range(15)), $urandom_range(99) < ab_pct, acc);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) idle(0);
   endtask

   task automatic request(input int cnt, input int gap, input int ab_pct, output int t);
      bit acc = 1'b0;
      int guard = 0;
      t = cyc;
      while (!acc && guard < 6000) begin
         t = cyc;
         step(1'b1, cnt, gap, $urandom_range(99) < ab_pct, acc);
         guard++;
      end
   endtask

   task automatic mid_reset();
      rstn = 1'b0;
      req_valid = 1'b0;
      abort = 1'b0;
      exp_q.delete();
      b_from = 1;
      b_to = 0;
      chk_em_cyc = -1;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // monitor: every pulse or done presented by the DUT is matched against the next expected event
   always @(negedge clk) begin
      if (!rstn) begin
         n_vec = n_vec + 1;
         if (pulse_out || busy || done || emitted != '0) begin
            n_err = n_err + 1;
            $display("FAIL reset cyc=%0d got pulse=%0b busy=%0b done=%0b emitted=%0d exp all zero",
                     cyc, pulse_out, busy, done, emitted);
         end
      end else begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL missed cyc=%0d exp %s at cyc=%0d em=%0d got nothing",
                     cyc, exp_q[0].is_done ? "done" : "pulse", exp_q[0].cyc, exp_q[0].em);
            void'(exp_q.pop_front());
         end
         if (pulse_out || done) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               n_err = n_err + 1;
               $display("FAIL unexpected cyc=%0d got pulse=%0b done=%0b exp no event", cyc, pulse_out, done);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               if (done != e.is_done || pulse_out == e.is_done || int'(emitted) != e.em) begin
                  n_err = n_err + 1;
                  $display("FAIL event cyc=%0d got pulse=%0b done=%0b emitted=%0d exp %s emitted=%0d",
                           cyc, pulse_out, done, emitted, e.is_done ? "done" : "pulse", e.em);
               end
            end
         end
         if (exp_cyc == cyc) begin
            n_vec = n_vec + 1;
            if (req_ready != exp_ready || busy != exp_busy) begin
               n_err = n_err + 1;
               $display("FAIL handshake cyc=%0d got ready=%0b busy=%0b exp ready=%0b busy=%0b",
                        cyc, req_ready, busy, exp_ready, exp_busy);
            end
         end
         if (chk_em_cyc == cyc) begin
            n_vec = n_vec + 1;
            if (int'(emitted) != chk_em_val || pulse_out || done) begin
               n_err = n_err + 1;
               $display("FAIL abort cyc=%0d got emitted=%0d pulse=%0b done=%0b exp emitted=%0d pulse=0 done=0",
                        cyc, emitted, pulse_out, done, chk_em_val);
            end
         end
      end
   end

   initial begin
      int t, t2, guard;
      bit acc;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      request(3, 2, 0, t);
      wait_until(t + 10);
      request(4, 0, 0, t);
      wait_until(t + 7);
      request(0, 5, 0, t);
      wait_until(t + 3);
      request(3, 1, 0, t);
      request(2, 1, 0, t2);
      wait_until(t2 + 6);
      request(5, 3, 0, t);
      wait_until(t + 5);
      step(1'b0, 0, 0, 1'b1, acc);
      step(1'b1, 7, 2, 1'b1, acc);
      wait_until(cyc + 3);
      request(10, 3, 0, t);
      wait_until(t + 3);
      mid_reset();
      request(1, 0, 0, t);
      wait_until(t + 4);
      request(255, 0, 0, t);
      wait_until(t + 258);
      request(2, 15, 0, t);
      for (int i = 0; i < 60; i++) begin
         int cnt, gap, pre;
         cnt = ($urandom_range(99) < 10) ? 0 : int'($urandom_range(12, 1));
         gap = int'($urandom_range(15));
         pre = int'($urandom_range(4));
         for (int j = 0; j < pre; j++) idle(3);
         request(cnt, gap, 3, t);
      end
      guard = 0;
      while ((exp_q.size() != 0 || cyc <= b_to + 2) && guard < 6000) begin
         idle(0);
         guard++;
      end
      repeat (2) idle(0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pulse_dispenser.md
Name: pulse_dispenser

Overview:
- Single-clock pulse generator; the transmitter-side counterpart to our pulse accumulation/crossing logic.
- Accepts a request of N pulses with a programmable inter-pulse gap over a valid/ready handshake.
- Emits exactly N single-cycle pulses spaced (gap+1) cycles apart.
- Drives downstream event inputs, e.g. accumulator pulse inputs and per-row/tile advance strobes in the convolution datapath.

Parameters:
- CNT_W, 8: width of pulse count and emitted counter; max request is 2^CNT_W-1 pulses.
- GAP_W, 4: width of the gap field; gap range is 0..2^GAP_W-1 idle cycles between pulses.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_count  input  CNT_W  number of pulses to emit; sampled on accept.
- req_gap  input  GAP_W  idle cycles between consecutive pulses; sampled on accept.
- abort  input  1  terminate current burst.
- pulse_out  output  1  single-cycle output pulse, registered.
- busy  output  1  burst in progress (state != IDLE).
- done  output  1  one-cycle strobe on normal burst completion, registered.
- emitted  output  CNT_W  pulses emitted in the current/last burst, registered.

Behaviour:
- Reset (rstn low, async): state=IDLE; pulse_out=0, done=0, emitted=0, busy=0; internal counters=0. An active burst is dropped immediately, with no done.
- States: IDLE, PULSE, GAP. pulse_out=1 exactly when state==PULSE. Decode from a registered state so no combinational path from inputs.
- req_ready = (state==IDLE) && !abort, combinational. Accept = req_valid && req_ready.
- IDLE, accept, req_count>0: latch remaining=req_count and gap=req_gap; emitted:=0; next state PULSE. First pulse is in the cycle after accept (latency 1).
- IDLE, accept, req_count==0: emitted:=0; stay IDLE; done=1 the next cycle; no pulses.
- PULSE: emitted += 1; remaining -= 1.
  - If remaining==1: next state IDLE, done=1 in that next cycle.
  - Else if gap==0: stay PULSE (back-to-back pulses).
  - Else: go to GAP with gap_cnt=gap.
- GAP: gap_cnt -= 1. When gap_cnt==1, next state PULSE. Pulse period is always gap+1 cycles.
- done is high for exactly one cycle, the first IDLE cycle after the last pulse. req_ready is also high in that cycle.
- A new request may be accepted in the done cycle. Its first pulse follows one cycle later. No gap is enforced between bursts.
- abort (synchronous, highest priority):
  - In any state, next state is IDLE and pulse_out=0 next cycle.
  - done is not asserted.
  - emitted holds the count of pulses actually emitted, including a pulse in the abort cycle itself.
- abort while IDLE: no effect, except that req_ready is forced low that cycle so a simultaneous req_valid is not accepted.
- req_count/req_gap changes while busy: ignored, since values are latched on accept.
- req_valid while busy: not accepted, no side effects. The requester must hold its request until accepted.
- emitted holds its value after completion until the next accept or reset. It cannot overflow because it is bounded by req_count.
- Arithmetic: all counters unsigned, no wrap reachable in legal operation.

Decomposition:
- Shared package (accel_pkg): state encoding localparams PD_IDLE=2'd0, PD_PULSE=2'd1, PD_GAP=2'd2; default CNT_W/GAP_W constants.
- One natural sub-module: pulse_gap_timer.
  - Load-and-count-down GAP_W counter with load, en, and expire output.
  - Reusable by other strobe generators.
- The FSM and the remaining/emitted counters stay in pulse_dispenser.

Test Plan:
- Reset, then req_count=3, req_gap=2 accepted at cycle T -> pulse_out high at T+1, T+4, T+7; done at T+8; emitted=3; busy high T+1..T+7.
- req_count=4, req_gap=0 -> pulse_out high 4 consecutive cycles T+1..T+4; done at T+5; req_ready low T+1..T+4.
- req_count=0 -> no pulse_out; done at T+1; emitted=0; busy never high.
- Back-to-back bursts: second request (count=2, gap=1) held valid and accepted in the done cycle D of the first -> pulses at D+1, D+3; done at D+4.
- req_count=5, req_gap=3; abort asserted in the cycle of the 2nd pulse -> pulse_out 0 next cycle; state IDLE; done never asserted; emitted=2. req_valid asserted together with abort in IDLE is not accepted.
- rstn deasserted-to-low mid-GAP during a count=10 burst -> pulse_out, busy, done, emitted all 0 immediately. After rstn release, a new count=1 request yields one pulse at T+1 and done at T+2.
